l2_mem_arbiter: RTL and testbench
=================================

# l2_mem_arbiter

Shares the single cacheline-wide physical memory port between the instruction-side L2 cache (read-only) and the data-side L2 cache (read/write). Sits between the two L2 caches and the cacheline adaptor in the mp4 top level. Serializes one full cacheline transaction at a time with round-robin fairness, and keeps per-side grant counters for performance measurement.

## Interface

**Parameters** (name, default, meaning)

- `LINE_W`, 256, cacheline width in bits.
- `ADDR_W`, 32, address width in bits.

**Ports** (name, direction, width, meaning)

- `clk` in 1: clock, rising edge.
- `rst` in 1: reset; asynchronous, active-low.
- `i_read` in 1: I-side line read request, held until `i_resp`.
- `i_addr` in ADDR_W: I-side line address.
- `i_rdata` out LINE_W: I-side read data.
- `i_resp` out 1: I-side transaction done.
- `d_read` in 1: D-side line read request, held until `d_resp`.
- `d_write` in 1: D-side line write request, held until `d_resp`.
- `d_addr` in ADDR_W: D-side line address.
- `d_wdata` in LINE_W: D-side write data.
- `d_rdata` out LINE_W: D-side read data.
- `d_resp` out 1: D-side transaction done.
- `mem_read` out 1: physical read strobe.
- `mem_write` out 1: physical write strobe.
- `mem_addr` out ADDR_W: physical address.
- `mem_wdata` out LINE_W: physical write data.
- `mem_rdata` in LINE_W: physical read data.
- `mem_resp` in 1: physical transaction done.
- `i_grant_cnt` out 32: count of I-side grants.
- `d_grant_cnt` out 32: count of D-side grants.

## Operation

**States**

- **IDLE:** no transaction in flight.
  - If exactly one side requests, grant that side.
  - If both sides request, grant the side not equal to `last_grant`.
  - On a grant: latch address, write data and operation into the `mem_*` registers, update `last_grant`, and increment that side's counter.
  - Move to I_BUSY or D_BUSY.
- **I_BUSY:** `mem_read`=1, `mem_write`=0, `mem_addr` = latched `i_addr`. On `mem_resp`, go to IDLE and clear `mem_read`.
- **D_BUSY:** `mem_read` or `mem_write` per the latched operation. On `mem_resp`, go to IDLE and clear both strobes.

**Rules**

- A D-side request is `d_read | d_write`. If both are asserted, it is treated as a write.
- `last_grant` resets to I, so the D side wins the first contested arbitration.
- Responses are combinational:
  - `i_resp` = `mem_resp` & (state==I_BUSY).
  - `d_resp` = `mem_resp` & (state==D_BUSY).
  - `i_rdata` and `d_rdata` both equal `mem_rdata`. They are meaningful only when the corresponding resp is asserted.
- Address and data changes on the requester inputs while BUSY are ignored, because the values were latched at grant.
- Counters are 32-bit and wrap modulo 2^32 (0xFFFFFFFF+1 → 0).

## Timing

**Reset**

- While `rst`=0, asynchronously: state=IDLE; `mem_read`, `mem_write`, `mem_addr`, `mem_wdata` = 0; both counters = 0; `last_grant`=I.
- `i_resp`/`d_resp` = 0 during reset.
- Reset mid-transaction abandons the transaction. No resp is issued for it.

**Latency**

- Request visible in IDLE at edge N → strobe asserted from cycle N+1.
- `mem_resp` in cycle K → requester resp in the same cycle K → IDLE in cycle K+1 → next grant at edge K+1 → next strobe in cycle K+2.
- One idle cycle separates back-to-back transactions. The requester drops its request after seeing resp, so it is never re-granted spuriously.

**Other timing rules**

- Strobes are registered and stay stable for the whole transaction. The `mem_*` outputs never glitch between grants.
- `mem_resp` received in IDLE is ignored: no resp is forwarded and no state changes.
- A request arriving while BUSY waits. Round-robin guarantees it is served no later than after the current transaction.

## Test plan

1. **Single I read:** `i_read`=1, `i_addr`=0x60. Memory responds after 5 cycles with `mem_rdata`=0xA5…A5.
   - `mem_read`=1 with `mem_addr`=0x60 from cycle 1.
   - `i_resp`=1 for exactly one cycle, `i_rdata`=0xA5…A5.
   - `i_grant_cnt`=1; `d_resp` stays 0.
2. **Simultaneous requests after reset:** `i_read` (0x100) and `d_write` (0x200, data 0x1234) asserted together and held.
   - D is served first: `mem_write`=1, `mem_addr`=0x200.
   - Then I: `mem_read`=1, `mem_addr`=0x100 starting 2 cycles after the D resp.
   - Counters end at 1/1.
3. **Sustained contention:** both sides continuously re-request for 10 transactions. Grants alternate D, I, D, I…; counters end at 5/5.
4. **Input change mid-transaction:** `d_read` plus `d_write` both asserted; `d_addr` changed while BUSY.
   - A write is issued.
   - `mem_addr` keeps the value latched at grant.
5. **Reset mid-transaction:** assert `rst`=0 while in I_BUSY.
   - All `mem_*` outputs and counters go to 0 immediately.
   - After release, the held `i_read` is re-granted cleanly.
6. **Spurious and wrap cases:**
   - `mem_resp` pulsed in IDLE: no resp, no state change.
   - Counter forced to 0xFFFFFFFF, then one grant: counter becomes 0.

Source files
------------

// File: rtl/l2_mem_arbiter.sv
// l2_mem_arbiter
//   Shares one cacheline-wide physical memory port between the I-side L2 (read
//   only) and the D-side L2 (read/write). One full line transaction at a time,
//   round-robin between the two sides when both request, with per-side grant
//   counters.
//
// Ports
//   clk, rst                 clock (rising edge), asynchronous active-low reset
//   i_read/i_addr            I-side line read request and address
//   i_rdata/i_resp           I-side read data and transaction-done pulse
//   d_read/d_write/d_addr    D-side request (write wins if both) and address
//   d_wdata                  D-side write data
//   d_rdata/d_resp           D-side read data and transaction-done pulse
//   mem_read/mem_write       registered physical strobes
//   mem_addr/mem_wdata       registered physical address / write data
//   mem_rdata/mem_resp       physical read data and transaction-done
//   i_grant_cnt/d_grant_cnt  free-running (wrapping) grant counters
module l2_mem_arbiter #(
    parameter int unsigned LINE_W = 256,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp,
    output logic [31:0]       i_grant_cnt,
    output logic [31:0]       d_grant_cnt
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIBusy = 2'd1,
        StDBusy = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              last_d_q, last_d_d;  // 1: last grant went to D
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [31:0]       i_cnt_q, i_cnt_d;
    logic [31:0]       d_cnt_q, d_cnt_d;

    logic i_req, d_req, grant_i, grant_d;

    assign i_req = i_read;
    assign d_req = d_read | d_write;
    // Contested: the side that did not win last time gets the port.
    assign grant_d = d_req & (~i_req | ~last_d_q);
    assign grant_i = i_req & (~d_req | last_d_q);

    always_comb begin
        state_d     = state_q;
        last_d_d    = last_d_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        i_cnt_d     = i_cnt_q;
        d_cnt_d     = d_cnt_q;

        unique case (state_q)
            StIdle: begin
                if (grant_d) begin
                    state_d     = StDBusy;
                    last_d_d    = 1'b1;
                    mem_write_d = d_write;
                    mem_read_d  = ~d_write;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    d_cnt_d     = d_cnt_q + 32'd1;
                end else if (grant_i) begin
                    state_d     = StIBusy;
                    last_d_d    = 1'b0;
                    mem_read_d  = 1'b1;
                    mem_write_d = 1'b0;
                    mem_addr_d  = i_addr;
                    i_cnt_d     = i_cnt_q + 32'd1;
                end
            end
            StIBusy, StDBusy: begin
                // Address/data are left as-is so mem_* never glitch between grants.
                if (mem_resp) begin
                    state_d     = StIdle;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            last_d_q    <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_cnt_q     <= '0;
            d_cnt_q     <= '0;
        end else begin
            state_q     <= state_d;
            last_d_q    <= last_d_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_cnt_q     <= i_cnt_d;
            d_cnt_q     <= d_cnt_d;
        end
    end

    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign i_grant_cnt = i_cnt_q;
    assign d_grant_cnt = d_cnt_q;

    assign i_resp  = mem_resp & (state_q == StIBusy);
    assign d_resp  = mem_resp & (state_q == StDBusy);
    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;

endmodule

// File: tb/tb_l2_mem_arbiter.sv
// Directed bench for l2_mem_arbiter: drives inputs and samples outputs on the
// falling clock edge, plays the physical memory by hand.
module tb_l2_mem_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_read;
    logic [31:0]  i_addr;
    logic [255:0] i_rdata;
    logic         i_resp;
    logic         d_read;
    logic         d_write;
    logic [31:0]  d_addr;
    logic [255:0] d_wdata;
    logic [255:0] d_rdata;
    logic         d_resp;
    logic         mem_read;
    logic         mem_write;
    logic [31:0]  mem_addr;
    logic [255:0] mem_wdata;
    logic [255:0] mem_rdata;
    logic         mem_resp;
    logic [31:0]  i_grant_cnt;
    logic [31:0]  d_grant_cnt;

    int n_total = 0;
    int n_bad   = 0;

    logic [255:0] obs_wdata;
    logic [255:0] pat_a5;

    always #5 clk = ~clk;

    l2_mem_arbiter #(
        .LINE_W(256),
        .ADDR_W(32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_read     (i_read),
        .i_addr     (i_addr),
        .i_rdata    (i_rdata),
        .i_resp     (i_resp),
        .d_read     (d_read),
        .d_write    (d_write),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_rdata    (d_rdata),
        .d_resp     (d_resp),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_resp   (mem_resp),
        .i_grant_cnt(i_grant_cnt),
        .d_grant_cnt(d_grant_cnt)
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        i_read    = 1'b0;
        d_read    = 1'b0;
        d_write   = 1'b0;
        mem_resp  = 1'b0;
        mem_rdata = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    // Called on a falling edge. Waits (bounded) for a strobe, holds the line
    // busy for 'delay' cycles, returns mem_resp for one cycle with 'rdata'.
    // exp_wait < 0 skips the grant-latency check.
    task automatic do_txn(input string tag, input int delay, input logic [255:0] rdata,
                          input logic exp_d_side, input logic [1:0] exp_op,
                          input logic [31:0] exp_addr, input int exp_wait,
                          input logic drop_i, input logic drop_d);
        int          n;
        logic [1:0]  op;
        logic [31:0] addr;
        logic        stable;
        logic        saw_i, saw_d;
        logic [255:0] rd;
        n = 0;
        while (!(mem_read | mem_write) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_start"}, 256'(mem_read | mem_write), 256'(1));
        if (exp_wait >= 0) check({tag, "_lat"}, 256'(n), 256'(exp_wait));
        op        = {mem_write, mem_read};
        addr      = mem_addr;
        obs_wdata = mem_wdata;
        check({tag, "_op"}, 256'(op), 256'(exp_op));
        check({tag, "_addr"}, 256'(addr), 256'(exp_addr));
        stable = 1'b1;
        repeat (delay) begin
            @(negedge clk);
            if ({mem_write, mem_read} != op || mem_addr != addr || i_resp || d_resp)
                stable = 1'b0;
        end
        check({tag, "_stable"}, 256'(stable), 256'(1));
        mem_resp  = 1'b1;
        mem_rdata = rdata;
        #1;
        saw_i = i_resp;
        saw_d = d_resp;
        rd    = exp_d_side ? d_rdata : i_rdata;
        check({tag, "_iresp"}, 256'(saw_i), 256'(!exp_d_side));
        check({tag, "_dresp"}, 256'(saw_d), 256'(exp_d_side));
        check({tag, "_rdata"}, rd, rdata);
        @(negedge clk);
        mem_resp = 1'b0;
        if (drop_i) i_read = 1'b0;
        if (drop_d) begin
            d_read  = 1'b0;
            d_write = 1'b0;
        end
        check({tag, "_idle"}, 256'({mem_write, mem_read}), 256'(0));
    endtask

    initial begin
        pat_a5 = {32{8'hA5}};
        i_addr  = '0;
        d_addr  = '0;
        d_wdata = '0;
        do_reset();

        // Reset state
        check("rst_strobes", 256'({mem_write, mem_read}), 256'(0));
        check("rst_addr", 256'(mem_addr), 256'(0));
        check("rst_wdata", mem_wdata, 256'(0));
        check("rst_cnts", 256'({i_grant_cnt, d_grant_cnt}), 256'(0));
        check("rst_resp", 256'({i_resp, d_resp}), 256'(0));

        // 1: single I read
        i_read = 1'b1;
        i_addr = 32'h60;
        do_txn("t1", 5, pat_a5, 1'b0, 2'b01, 32'h60, 1, 1'b1, 1'b0);
        check("t1_icnt", 256'(i_grant_cnt), 256'(1));
        check("t1_dcnt", 256'(d_grant_cnt), 256'(0));

        // 2: simultaneous after reset, D wins first
        do_reset();
        i_read  = 1'b1;
        i_addr  = 32'h100;
        d_write = 1'b1;
        d_addr  = 32'h200;
        d_wdata = 256'h1234;
        do_txn("t2d", 3, 256'h77, 1'b1, 2'b10, 32'h200, 1, 1'b0, 1'b1);
        check("t2_wdata", obs_wdata, 256'h1234);
        do_txn("t2i", 2, 256'h88, 1'b0, 2'b01, 32'h100, 1, 1'b1, 1'b0);
        check("t2_cnts", 256'({i_grant_cnt, d_grant_cnt}), 256'({32'd1, 32'd1}));

        // 3: sustained contention, alternating D/I
        do_reset();
        i_read  = 1'b1;
        i_addr  = 32'h1000;
        d_write = 1'b1;
        d_addr  = 32'h2000;
        d_wdata = 256'hCAFE;
        for (int k = 0; k < 10; k++) begin
            if (k % 2 == 0)
                do_txn("t3d", 1, 256'(k + 100), 1'b1, 2'b10, 32'h2000, 1, 1'b0, k == 8);
            else
                do_txn("t3i", 2, 256'(k + 200), 1'b0, 2'b01, 32'h1000, 1, k == 9, 1'b0);
        end
        check("t3_icnt", 256'(i_grant_cnt), 256'(5));
        check("t3_dcnt", 256'(d_grant_cnt), 256'(5));

        // 4: read+write together is a write; inputs changed while busy are ignored
        do_reset();
        d_read  = 1'b1;
        d_write = 1'b1;
        d_addr  = 32'h300;
        d_wdata = 256'hBEEF;
        @(negedge clk);
        d_addr  = 32'h999;
        d_wdata = 256'hDEAD;
        @(negedge clk);
        check("t4_wr", 256'({mem_write, mem_read}), 256'(2'b10));
        check("t4_addr", 256'(mem_addr), 256'(32'h300));
        check("t4_wdata", mem_wdata, 256'hBEEF);
        do_txn("t4", 1, 256'h5, 1'b1, 2'b10, 32'h300, -1, 1'b0, 1'b1);

        // 5: reset in the middle of an I transaction
        do_reset();
        i_read = 1'b1;
        i_addr = 32'h400;
        @(negedge clk);
        check("t5_busy", 256'(mem_read), 256'(1));
        rst      = 1'b0;
        mem_resp = 1'b1;
        #1;
        check("t5_rd", 256'({mem_write, mem_read}), 256'(0));
        check("t5_addr", 256'(mem_addr), 256'(0));
        check("t5_cnt", 256'(i_grant_cnt), 256'(0));
        check("t5_resp", 256'({i_resp, d_resp}), 256'(0));
        @(negedge clk);
        mem_resp = 1'b0;
        rst      = 1'b1;
        do_txn("t5", 2, 256'h9, 1'b0, 2'b01, 32'h400, 1, 1'b1, 1'b0);
        check("t5_cnt2", 256'(i_grant_cnt), 256'(1));

        // 6a: mem_resp in IDLE is ignored
        mem_resp = 1'b1;
        #1;
        check("t6_resp", 256'({i_resp, d_resp}), 256'(0));
        @(negedge clk);
        mem_resp = 1'b0;
        @(negedge clk);
        check("t6_strobe", 256'({mem_write, mem_read}), 256'(0));
        check("t6_cnt", 256'({i_grant_cnt, d_grant_cnt}), 256'({32'd1, 32'd0}));
        check("t6_addr", 256'(mem_addr), 256'(32'h400));

        // 6b: counter wrap
        force dut.i_cnt_q = 32'hFFFF_FFFF;
        force dut.d_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.i_cnt_q;
        release dut.d_cnt_q;
        @(negedge clk);
        check("t6_preset", 256'(i_grant_cnt), 256'(32'hFFFF_FFFF));
        i_read = 1'b1;
        i_addr = 32'h500;
        do_txn("t6i", 1, 256'h1, 1'b0, 2'b01, 32'h500, 1, 1'b1, 1'b0);
        check("t6_iwrap", 256'(i_grant_cnt), 256'(0));
        d_read = 1'b1;
        d_addr = 32'h600;
        do_txn("t6d", 1, 256'h2, 1'b1, 2'b01, 32'h600, 1, 1'b0, 1'b1);
        check("t6_dwrap", 256'(d_grant_cnt), 256'(0));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
